mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the second (B) port of the unified instruction/data memory between NUM_REQ on-chip requesters (e.g. VGA reader, input poller, DMA).
// - Single-cycle accesses; round-robin arbitration; optional per-requester lock for read-modify-write.
// - Sits between the requesters and memory port B: addr2/dataIn2/we2/dataOut2.
// - The CPU keeps exclusive use of port A and the fetch path.
// PARAMETERS
// DATA_WIDTH  16  memory word width
// ADDR_WIDTH  16  memory word-address width
// NUM_REQ     3   number of requesters (>=2); index 0 has highest priority at reset
// PORTS
// clk         in   1                    system clock, all logic on posedge
// reset       in   1                    synchronous, active-high
// req         in   NUM_REQ              per-requester access request; held until granted
// lock        in   NUM_REQ              keep ownership of port after grant (RMW)
// we_req      in   NUM_REQ              1 = write, 0 = read
// addr_req    in   NUM_REQ*ADDR_WIDTH   flat; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// wdata_req   in   NUM_REQ*DATA_WIDTH   flat; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// gnt         out  NUM_REQ              one-hot-or-zero, combinational; access issued at this edge
// rvalid      out  NUM_REQ              registered; read data valid for requester i this cycle
// rdata       out  DATA_WIDTH           shared read data = mem_dout (qualify with rvalid)
// mem_addr    out  ADDR_WIDTH           to memory addr2
// mem_din     out  DATA_WIDTH           to memory dataIn2
// mem_we      out  1                    to memory we2
// mem_dout    in   DATA_WIDTH           from memory dataOut2
// BEHAVIOUR
// - Reset (sync): state=ARB, rr_ptr=NUM_REQ-1, owner=0, rvalid=0.
//   While reset=1: gnt=0, mem_we=0, mem_addr=0, mem_din=0.
// - Winner select (combinational):
//   - ARB: first i with req[i]=1, scanning from rr_ptr+1 upward mod NUM_REQ.
//   - LOCKED: only owner is eligible; all others see gnt=0.
// - Winner w: gnt[w]=1; mem_addr/mem_din/mem_we driven from w's addr/wdata/we_req. No winner: mem_we=0, mem_addr holds last value.
// - Write latency: memory is written at the granting edge.
// - Read latency: 1 cycle. rvalid[w]=1 the cycle after the grant; rdata=mem_dout in that cycle.
// - Back-to-back grants to any mix of requesters are allowed every cycle (full throughput).
// - rr_ptr <= w on every grant in either state.
// - FSM:
//   - ARB->LOCKED when gnt[w] & lock[w]; owner<=w.
//   - LOCKED->ARB at any edge where lock[owner]=0; a grant to owner in that same cycle is still issued.
//   - LOCKED with req[owner]=0: idle cycle, no grant.
// - Requester protocol: req/we_req/addr/wdata stable while req=1 and gnt=0. Dropping req before grant is legal; no access occurs.
// - Fairness: with all NUM_REQ continuously requesting in ARB, each receives exactly 1 grant every NUM_REQ cycles.
// - Addresses forwarded unmodified; wrap/range is the memory's concern.
// - Reset mid-operation: pending rvalid is discarded; a lock in progress is released.
// CONFIGURATION
// - MEMARB_FIXED_PRIORITY_EN defined:
//   - Selection is always lowest-index-first; rr_ptr is ignored and removed.
//   - Lock FSM unchanged.
// - Not defined (default): round-robin as above.
// TESTING
// 1. reset, then req=3'b111, all reads, addr0=0x10, addr1=0x20, addr2=0x30.
//    -> gnt sequence 001,010,100,001...; rvalid follows gnt 1 cycle later with rdata=mem[addr].
// 2. req0 write 0xBEEF to 0x0040 (granted); next cycle req1 read 0x0040.
//    -> rvalid[1]=1 with rdata=0xBEEF.
// 3. req1 lock=1 read 0x0050; req0 and req2 pending. -> only req1 granted while lock[1]=1.
//    req1 then writes 0x0050 <= old+1; lock drops -> arbitration resumes at req2.
// 4. reset asserted in the cycle after a read grant -> rvalid=0, gnt=0, mem_we=0.
//    After release, req0 is granted first.
// 5. req2 asserts, then drops before grant (req0 busy) -> no access to addr2 and no rvalid[2].
// 6. MEMARB_FIXED_PRIORITY_EN, req=3'b011 held 4 cycles -> gnt=001 every cycle; req1 starves (expected).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares port B of the unified instruction/data memory between NUM_REQ on-chip
// requesters (VGA reader, input poller, DMA, ...). Each access takes a single
// cycle. Arbitration is round-robin, and a requester can hold a lock on the
// port across a read-modify-write sequence.
//
// Optional feature macro: MEMARB_FIXED_PRIORITY_EN
//   defined   -> the lowest requesting index always wins; no round-robin pointer
//   undefined -> round-robin starting after the most recent winner (default)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   req        in   per-requester access request, held until granted
//   lock       in   keep ownership of the port after a grant (RMW)
//   we_req     in   1 = write, 0 = read
//   addr_req   in   flat, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_req  in   flat, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        out  one-hot-or-zero, combinational; access issued at this edge
//   rvalid     out  registered; read data valid for requester i this cycle
//   rdata      out  shared read data (qualify with rvalid)
//   mem_addr   out  memory addr2
//   mem_din    out  memory dataIn2
//   mem_we     out  memory we2
//   mem_dout   in   memory dataOut2
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_REQ    = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               lock,
   input  logic [NUM_REQ-1:0]               we_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_req,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rvalid,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_din,
   output logic                             mem_we,
   input  logic [DATA_WIDTH-1:0]            mem_dout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {ARB, LOCKED} state_t;

   state_t               state;
   state_t               next_state;
   logic [IDX_W-1:0]     owner;
   logic [IDX_W-1:0]     win;
   logic                 win_valid;
   logic [NUM_REQ-1:0]   rvalid_q;
   logic [ADDR_WIDTH-1:0] last_addr;
`ifndef MEMARB_FIXED_PRIORITY_EN
   logic [IDX_W-1:0]     rr_ptr;
`endif

   // Winner selection. While locked only the owner may win. Otherwise the
   // candidates are scanned so that the preferred one is visited last and
   // therefore overrides any earlier match.
   always_comb begin
      logic [IDX_W-1:0] cand;
      win       = '0;
      win_valid = 1'b0;
      cand      = '0;
      if (state == LOCKED) begin
         if (req[owner]) begin
            win       = owner;
            win_valid = 1'b1;
         end
      end else begin
`ifdef MEMARB_FIXED_PRIORITY_EN
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) begin
               win       = cand;
               win_valid = 1'b1;
            end
         end
`else
         for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
               win       = cand;
               win_valid = 1'b1;
            end
         end
`endif
      end
      if (reset) begin
         win_valid = 1'b0;
      end
   end

   // State register for the lock FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a locked grant captures the port; the owner releases
   // it simply by dropping lock, even in a cycle where it is still granted.
   always_comb begin
      next_state = state;
      case (state)
         ARB: begin
            if (win_valid && lock[win]) begin
               next_state = LOCKED;
            end
         end
         LOCKED: begin
            if (!lock[owner]) begin
               next_state = ARB;
            end
         end
         default: next_state = ARB;
      endcase
   end

   // Output logic. The memory port is steered straight from the winner so the
   // access lands at the granting edge. With no winner the address holds its
   // previous value. Reset forces the port quiet and hides any pending rvalid.
   always_comb begin
      gnt      = '0;
      mem_we   = 1'b0;
      mem_din  = '0;
      mem_addr = reset ? '0 : last_addr;
      if (win_valid) begin
         gnt[win] = 1'b1;
         mem_we   = we_req[win];
         mem_din  = wdata_req[int'(win)*DATA_WIDTH +: DATA_WIDTH];
         mem_addr = addr_req[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      rvalid = rvalid_q & {NUM_REQ{~reset}};
      rdata  = mem_dout;
   end

   // Datapath registers: lock owner, round-robin pointer, read-valid pipeline
   // and the held address.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= '0;
         rvalid_q  <= '0;
         last_addr <= '0;
`ifndef MEMARB_FIXED_PRIORITY_EN
         rr_ptr    <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         rvalid_q <= '0;
         if (win_valid) begin
            rvalid_q[win] <= ~we_req[win];
            last_addr     <= mem_addr;
`ifndef MEMARB_FIXED_PRIORITY_EN
            rr_ptr        <= win;
`endif
            if (state == ARB && lock[win]) begin
               owner <= win;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A simple memory stands in for
// port B. Each cycle the bench predicts the grant from the arbitration rules
// and queues the expected read result; a separate monitor pops and compares
// whenever the read pipeline delivers.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int N  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req, lock, we_req;
   logic [N*AW-1:0] addr_req;
   logic [N*DW-1:0] wdata_req;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata, mem_din, mem_dout;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .we_req(we_req),
      .addr_req(addr_req), .wdata_req(wdata_req), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Memory behind port B: write at the edge, registered read.
   logic [DW-1:0] ram    [0:65535];
   logic [DW-1:0] shadow [0:65535];

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           expq[$];
   int            errors = 0;
   int            checks = 0;

   // Reference model state.
   int            lastGrant;
   int            lockOwner;
   logic [AW-1:0] lastAddr;
   int            prevWin;

   logic [AW-1:0] addr_v  [N];
   logic [DW-1:0] wdata_v [N];

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Predict this cycle's grant and port drive, then advance the model as if
   // the coming edge has happened.
   task automatic checkOutput();
      int            w;
      logic [AW-1:0] expAddr;
      logic          expWe;
      w = -1;
      if (reset) begin
         compare("reset_gnt", 32'(gnt), 32'd0);
         compare("reset_we", 32'(mem_we), 32'd0);
         compare("reset_addr", 32'(mem_addr), 32'd0);
         compare("reset_din", 32'(mem_din), 32'd0);
         lastGrant = N - 1;
         lockOwner = -1;
         lastAddr  = '0;
         prevWin   = -1;
         expq.delete();
         return;
      end
      if (lockOwner >= 0) begin
         if (req[lockOwner]) w = lockOwner;
      end else begin
`ifdef MEMARB_FIXED_PRIORITY_EN
         for (int i = 0; i < N; i++)
            if (w < 0 && req[i]) w = i;
`else
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(lastGrant + k) % N]) w = (lastGrant + k) % N;
`endif
      end
      expWe   = (w >= 0) ? we_req[w] : 1'b0;
      expAddr = (w >= 0) ? addr_req[w*AW +: AW] : lastAddr;
      compare("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
      compare("mem_we", 32'(mem_we), 32'(expWe));
      compare("mem_addr", 32'(mem_addr), 32'(expAddr));
      if (w >= 0 && expWe) begin
         compare("mem_din", 32'(mem_din), 32'(wdata_req[w*DW +: DW]));
         shadow[expAddr] = wdata_req[w*DW +: DW];
      end
      if (w >= 0 && !expWe) expq.push_back('{idx: w, data: shadow[expAddr]});
      if (lockOwner >= 0) begin
         if (!lock[lockOwner]) lockOwner = -1;
      end else if (w >= 0 && lock[w]) begin
         lockOwner = w;
      end
      if (w >= 0) begin
         lastGrant = w;
         lastAddr  = expAddr;
      end
      prevWin = w;
   endtask

   task automatic applyStimulus(input logic rst, input logic [N-1:0] r, input logic [N-1:0] lk,
                                input logic [N-1:0] w);
      @(negedge clk);
      reset  = rst;
      req    = r;
      lock   = lk;
      we_req = w;
      for (int i = 0; i < N; i++) begin
         addr_req[i*AW +: AW]  = addr_v[i];
         wdata_req[i*DW +: DW] = wdata_v[i];
      end
      #1;
      checkOutput();
   endtask

   // Monitor: after every edge, either the queued read is delivered or
   // nothing is.
   initial begin
      rd_t e;
      forever begin
         @(posedge clk);
         #2;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            compare("rvalid", 32'(rvalid), 32'd1 << e.idx);
            compare("rdata", 32'(rdata), 32'(e.data));
         end else begin
            compare("rvalid_idle", 32'(rvalid), 32'd0);
         end
      end
   end

   initial begin
      logic [N-1:0] rr, ww, lk;
      for (int i = 0; i < 65536; i++) begin
         ram[i]    = 16'(i * 7 + 3);
         shadow[i] = 16'(i * 7 + 3);
      end
      for (int i = 0; i < N; i++) begin
         addr_v[i]  = '0;
         wdata_v[i] = '0;
      end
      reset = 1'b1; req = '0; lock = '0; we_req = '0;
      addr_req = '0; wdata_req = '0;
      lastGrant = N - 1; lockOwner = -1; lastAddr = '0; prevWin = -1;

      // Reset holds the port quiet even with requests present.
      addr_v[0] = 16'h0010; addr_v[1] = 16'h0020; addr_v[2] = 16'h0030;
      applyStimulus(1'b1, 3'b000, 3'b000, 3'b000);
      applyStimulus(1'b1, 3'b111, 3'b000, 3'b111);

      // All three reading continuously: strict rotation.
      for (int c = 0; c < 7; c++) applyStimulus(1'b0, 3'b111, 3'b000, 3'b000);

      // Write then read back through another requester.
      addr_v[0] = 16'h0040; wdata_v[0] = 16'hBEEF;
      applyStimulus(1'b0, 3'b001, 3'b000, 3'b001);
      addr_v[1] = 16'h0040;
      applyStimulus(1'b0, 3'b010, 3'b000, 3'b000);
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);

      // Locked read-modify-write by requester 1.
      addr_v[0] = 16'h0011; addr_v[2] = 16'h0033;
      applyStimulus(1'b0, 3'b001, 3'b000, 3'b000);
      addr_v[1] = 16'h0050;
      applyStimulus(1'b0, 3'b111, 3'b010, 3'b000);
      applyStimulus(1'b0, 3'b101, 3'b010, 3'b000);
      wdata_v[1] = shadow[16'h0050] + 16'd1;
      applyStimulus(1'b0, 3'b111, 3'b000, 3'b010);
      applyStimulus(1'b0, 3'b101, 3'b000, 3'b000);
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);

      // Reset in the cycle after a read grant discards the pending rvalid.
      addr_v[0] = 16'h0012;
      applyStimulus(1'b0, 3'b001, 3'b000, 3'b000);
      applyStimulus(1'b1, 3'b001, 3'b000, 3'b000);
      compare("reset_rvalid", 32'(rvalid), 32'd0);
      applyStimulus(1'b0, 3'b111, 3'b000, 3'b000);

      // Requester 2 gives up while requester 0 holds the port.
      addr_v[2] = 16'h0077;
      applyStimulus(1'b0, 3'b001, 3'b001, 3'b000);
      applyStimulus(1'b0, 3'b101, 3'b001, 3'b000);
      applyStimulus(1'b0, 3'b001, 3'b001, 3'b000);
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);

      // Two requesters held for four cycles (starvation under fixed priority).
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 3'b011, 3'b000, 3'b000);

      // Randomized traffic that obeys the requester protocol.
      rr = '0; ww = '0; lk = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rr[i] && prevWin != i) begin
               if ($urandom % 16 == 0) rr[i] = 1'b0;
            end else begin
               rr[i]      = 1'($urandom % 2);
               ww[i]      = 1'($urandom % 2);
               addr_v[i]  = 16'($urandom % 64);
               wdata_v[i] = 16'($urandom);
            end
            lk[i] = ($urandom % 4 == 0);
         end
         applyStimulus(1'b0, rr, lk, ww);
      end
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);
      applyStimulus(1'b0, 3'b000, 3'b000, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
